// File: rtl/fifo_pipeline_if.sv
// Handshake bundle for fifo_pipeline: write side (data_in/shift_in),
// pop side (shift_out) and the first-word fall-through status outputs.
interface fifo_pipeline_if #(
  parameter int DATA = 32
) ();
  logic [DATA-1:0] data_in;
  logic            shift_in;
  logic            shift_out;
  logic [DATA-1:0] data_out;
  logic            empty;
  logic            full;

  // The producer/consumer side drives requests and observes status.
  modport master (
    output data_in, shift_in, shift_out,
    input  data_out, empty, full
  );

  // The FIFO itself.
  modport slave (
    input  data_in, shift_in, shift_out,
    output data_out, empty, full
  );
endinterface

// File: rtl/fifo_pipeline.sv
// Circular-buffer FIFO of SIZE words with first-word fall-through output.
// Occupancy is an explicit count, so any depth >= 2 is supported.
module fifo_pipeline #(
  parameter int SIZE = 5,
  parameter int DATA = 32
) (
  input  logic           clk,
  input  logic           reset,
  fifo_pipeline_if.slave bus
);

  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = $clog2(SIZE + 1);

  localparam logic [PW-1:0] PTR_LAST  = PW'(SIZE - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(SIZE);

  logic [DATA-1:0] mem_q [SIZE];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic is_empty;
  logic is_full;
  logic do_pop;
  logic do_push;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);

  // A pop frees a slot in the same edge, so a full FIFO may still accept a write
  // when both requests arrive together; an empty FIFO can only take the write.
  assign do_pop  = bus.shift_out && !is_empty;
  assign do_push = bus.shift_in  && (!is_full || do_pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; stale words are unreachable because
  // an empty FIFO forces data_out to zero, and skipping the reset keeps it a RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  always_comb begin
    bus.data_out = '0;
    if (!is_empty) bus.data_out = mem_q[rd_ptr_q];
  end

  assign bus.empty = is_empty;
  assign bus.full  = is_full;

endmodule

// File: tb/tb_fifo_pipeline.sv
// Self-checking bench for fifo_pipeline: constant vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_fifo_pipeline;

  localparam int SIZE = 5;
  localparam int DATA = 32;

  logic clk;
  logic reset;
  fifo_pipeline_if #(.DATA(DATA)) bus ();

  fifo_pipeline #(.SIZE(SIZE), .DATA(DATA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the stored words as a plain queue, head at index 0.
  logic [DATA-1:0] model_q[$];

  task automatic check(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [DATA-1:0] model_out();
    return (model_q.size() == 0) ? '0 : model_q[0];
  endfunction

  task automatic model_apply(input bit si, input bit so, input logic [DATA-1:0] d);
    bit pop, push;
    if (!reset) begin
      model_q.delete();
      return;
    end
    pop  = so && (model_q.size() > 0);
    push = si && ((model_q.size() < SIZE) || pop);
    if (pop)  void'(model_q.pop_front());
    if (push) model_q.push_back(d);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data_out"}, bus.data_out, model_out());
    check({tag, ".empty"}, DATA'(bus.empty), DATA'(model_q.size() == 0));
    check({tag, ".full"},  DATA'(bus.full),  DATA'(model_q.size() == SIZE));
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge,
  // return 1 time unit after the rising edge so outputs can be sampled.
  task automatic step(input bit si, input bit so, input logic [DATA-1:0] d);
    @(negedge clk);
    bus.shift_in  = si;
    bus.shift_out = so;
    bus.data_in   = d;
    @(posedge clk);
    model_apply(si, so, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.shift_in  = 1'b0;
    bus.shift_out = 1'b0;
    reset = 1'b0;
    model_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit              si;
    bit              so;
    logic [DATA-1:0] d;
    logic [DATA-1:0] exp_out;
    bit              exp_empty;
    bit              exp_full;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [DATA-1:0] seen[$];
    logic [DATA-1:0] sent[$];
    logic [DATA-1:0] last_popped;
    logic [DATA-1:0] w;

    // Fill from empty, overflow attempt, then drain.
    vecs[0]  = '{1, 0, 32'hA0, 32'hA0, 0, 0};
    vecs[1]  = '{1, 0, 32'hA1, 32'hA0, 0, 0};
    vecs[2]  = '{1, 0, 32'hA2, 32'hA0, 0, 0};
    vecs[3]  = '{1, 0, 32'hA3, 32'hA0, 0, 0};
    vecs[4]  = '{1, 0, 32'hA4, 32'hA0, 0, 1};
    vecs[5]  = '{1, 0, 32'hFF, 32'hA0, 0, 1};
    vecs[6]  = '{0, 1, 32'h00, 32'hA1, 0, 0};
    vecs[7]  = '{0, 1, 32'h00, 32'hA2, 0, 0};
    vecs[8]  = '{0, 1, 32'h00, 32'hA3, 0, 0};
    vecs[9]  = '{0, 1, 32'h00, 32'hA4, 0, 0};
    vecs[10] = '{0, 1, 32'h00, 32'h00, 1, 0};
    vecs[11] = '{0, 1, 32'h00, 32'h00, 1, 0};
    vecs[12] = '{1, 1, 32'h5A, 32'h5A, 0, 0};

    reset = 1'b0;
    bus.shift_in  = 1'b0;
    bus.shift_out = 1'b0;
    bus.data_in   = '0;
    #12;
    check("reset.data_out", bus.data_out, '0);
    check("reset.empty", DATA'(bus.empty), 32'd1);
    check("reset.full",  DATA'(bus.full),  32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Three writes after reset; head visible one edge after the first write.
    step(1, 0, 32'h11111111);
    check("w3.first.empty", DATA'(bus.empty), 32'd0);
    check("w3.first.data_out", bus.data_out, 32'h11111111);
    step(1, 0, 32'h22222222);
    step(1, 0, 32'h33333333);
    check("w3.data_out", bus.data_out, 32'h11111111);
    check("w3.full", DATA'(bus.full), 32'd0);

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].si, vecs[i].so, vecs[i].d);
      check($sformatf("vec%0d.data_out", i), bus.data_out, vecs[i].exp_out);
      check($sformatf("vec%0d.empty", i), DATA'(bus.empty), DATA'(vecs[i].exp_empty));
      check($sformatf("vec%0d.full", i),  DATA'(bus.full),  DATA'(vecs[i].exp_full));
    end

    // Simultaneous push/pop while full: count holds at SIZE, B5 ends the drain.
    do_reset();
    for (int i = 0; i < SIZE; i++) step(1, 0, 32'hB0 + DATA'(i));
    step(1, 1, 32'hB5);
    check("fullboth.full", DATA'(bus.full), 32'd1);
    check("fullboth.data_out", bus.data_out, 32'hB1);
    last_popped = '0;
    for (int i = 0; i < SIZE; i++) begin
      last_popped = bus.data_out;
      step(0, 1, '0);
    end
    check("fullboth.last", last_popped, 32'hB5);
    check("fullboth.empty", DATA'(bus.empty), 32'd1);

    // Simultaneous push/pop while empty: only the write takes effect.
    step(1, 1, 32'hC1);
    check("emptyboth.empty", DATA'(bus.empty), 32'd0);
    check("emptyboth.data_out", bus.data_out, 32'hC1);
    step(0, 1, '0);
    step(0, 1, '0);
    check("emptypop.empty", DATA'(bus.empty), 32'd1);
    check("emptypop.data_out", bus.data_out, 32'h0);

    // Alternating writes and pops across several pointer wraps.
    step(1, 0, 32'hD000);
    sent.push_back(32'hD000);
    for (int i = 1; i <= 16; i++) begin
      seen.push_back(bus.data_out);
      w = 32'hD000 + DATA'(i);
      step(1, 1, w);
      if (i < 16) sent.push_back(w);
    end
    foreach (sent[i]) check($sformatf("wrap.order%0d", i), seen[i], sent[i]);

    // Asynchronous reset between edges with three words loaded.
    do_reset();
    step(1, 0, 32'hE1);
    step(1, 0, 32'hE2);
    step(1, 0, 32'hE3);
    #2;
    reset = 1'b0;
    model_q.delete();
    #1;
    check("async.data_out", bus.data_out, '0);
    check("async.empty", DATA'(bus.empty), 32'd1);
    check("async.full",  DATA'(bus.full),  32'd0);
    step(1, 1, 32'hEE);
    step(1, 0, 32'hEF);
    check_model("inreset");
    @(negedge clk);
    reset = 1'b1;
    step(0, 1, '0);
    check_model("postreset.pop");
    step(1, 0, 32'hE9);
    check("postreset.data_out", bus.data_out, 32'hE9);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), $urandom);
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
